// File: rtl/nic_mac_status_pkg.sv
// Shared definitions for the MAC status return path: status word layout and
// transmit FSM encoding.
package nic_mac_status_pkg;

    localparam int STAT_LINK_UP_BIT    = 0;
    localparam int STAT_RESET_DONE_BIT = 1;
    localparam int STAT_SEQ_LSB        = 4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEND = 2'd2
    } tx_state_e;

    // status is {reset_done, link_up}; unused bits 3:2 stay zero
    function automatic logic [7:0] make_status_word(input logic [1:0] status,
                                                    input logic [3:0] seq);
        logic [7:0] word;
        word = 8'h00;
        word[STAT_LINK_UP_BIT]    = status[0];
        word[STAT_RESET_DONE_BIT] = status[1];
        word[STAT_SEQ_LSB +: 4]   = seq;
        return word;
    endfunction

endpackage

// File: rtl/nic_status_debounce.sv
// Two-flop synchroniser followed by a mismatch-counting debouncer for one
// asynchronous status bit.
module nic_status_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic stable_out
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q;
    logic        sync2_q;
    logic        stable_q;
    logic        stable_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("nic_status_debounce: DEBOUNCE_CYCLES must be 1..65535");
    end

    // The stable value flips on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = 16'd0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= 16'd0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_out = stable_q;

endmodule

// File: rtl/nic_mac_status_pipe_tx.sv
// Writes debounced MAC status words into a req/ack output pipe: one word after
// reset, then one per status change, coalescing changes seen while stalled.
module nic_mac_status_pipe_tx #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int          DATA_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MAC_LINK_UP,
    input  logic                  MAC_RESET_DONE,
    output logic [DATA_WIDTH-1:0] MAC_STATUS_pipe_data,
    output logic                  MAC_STATUS_pipe_req,
    input  logic                  MAC_STATUS_pipe_ack,
    output logic [15:0]           words_sent
);

    import nic_mac_status_pkg::*;

    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("nic_mac_status_pipe_tx: DATA_WIDTH must be 8");
    end

    logic        link_up_stable;
    logic        reset_done_stable;
    logic [1:0]  status;
    logic        xfer;

    tx_state_e   state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        req_q, req_d;
    logic [1:0]  last_sent_q, last_sent_d;
    logic [3:0]  seq_q, seq_d;
    logic [15:0] words_sent_q, words_sent_d;

    nic_status_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_link_up_db (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (MAC_LINK_UP),
        .stable_out (link_up_stable)
    );

    nic_status_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_done_db (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (MAC_RESET_DONE),
        .stable_out (reset_done_stable)
    );

    assign status = {reset_done_stable, link_up_stable};
    assign xfer   = req_q & MAC_STATUS_pipe_ack;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        req_d        = req_q;
        last_sent_d  = last_sent_q;
        seq_d        = seq_q;
        words_sent_d = words_sent_q;
        case (state_q)
            ST_INIT: begin
                data_d  = make_status_word(status, seq_q);
                req_d   = 1'b1;
                state_d = ST_SEND;
            end
            ST_IDLE: begin
                if (status != last_sent_q) begin
                    data_d  = make_status_word(status, seq_q);
                    req_d   = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Only the status present at transfer time matters, so any
                // changes during a stall collapse into at most one follow-up.
                if (xfer) begin
                    last_sent_d  = {data_q[STAT_RESET_DONE_BIT], data_q[STAT_LINK_UP_BIT]};
                    seq_d        = seq_q + 4'd1;
                    words_sent_d = words_sent_q + 16'd1;
                    if (status != last_sent_d) begin
                        data_d = make_status_word(status, seq_d);
                        req_d  = 1'b1;
                    end else begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            data_q       <= 8'h00;
            req_q        <= 1'b0;
            last_sent_q  <= 2'b00;
            seq_q        <= 4'd0;
            words_sent_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            req_q        <= req_d;
            last_sent_q  <= last_sent_d;
            seq_q        <= seq_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign MAC_STATUS_pipe_data = data_q;
    assign MAC_STATUS_pipe_req  = req_q;
    assign words_sent           = words_sent_q;

endmodule

// File: tb/tb_nic_mac_status_pipe_tx.sv
// Directed bench for nic_mac_status_pipe_tx: reset word, debounce timing,
// glitch rejection, stalled-send coalescing and reset during a send.
module tb_nic_mac_status_pipe_tx;

    logic        clk;
    logic        reset;
    logic        macLinkUp;
    logic        macResetDone;
    logic [7:0]  pipeData;
    logic        pipeReq;
    logic        pipeAck;
    logic [15:0] wordsSent;

    int checkCount;
    int errorCount;

    nic_mac_status_pipe_tx #(.DEBOUNCE_CYCLES(16), .DATA_WIDTH(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .MAC_LINK_UP          (macLinkUp),
        .MAC_RESET_DONE       (macResetDone),
        .MAC_STATUS_pipe_data (pipeData),
        .MAC_STATUS_pipe_req  (pipeReq),
        .MAC_STATUS_pipe_ack  (pipeAck),
        .words_sent           (wordsSent)
    );

    // Free-running 10 ns clock; stimulus and sampling both happen on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic linkUp, input logic resetDone, input logic ack);
        macLinkUp    = linkUp;
        macResetDone = resetDone;
        pipeAck      = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic waitReq(input int budget, output logic found, output int cycles);
        found  = 1'b0;
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (pipeReq === 1'b1) begin
                found  = 1'b1;
                cycles = i;
                break;
            end
        end
    endtask

    task automatic countReq(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pipeReq === 1'b1) seen++;
        end
    endtask

    logic found;
    int   cycles;
    int   seen;

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitCycles(3);

        // Reset state
        checkOutput("reset_req", 32'(pipeReq), 32'h0);
        checkOutput("reset_data", 32'(pipeData), 32'h00);
        checkOutput("reset_words", 32'(wordsSent), 32'h0);

        // First word after reset release
        reset = 1'b0;
        @(negedge clk);
        checkOutput("init_req", 32'(pipeReq), 32'h1);
        checkOutput("init_data", 32'(pipeData), 32'h00);
        @(negedge clk);
        checkOutput("init_req_drop", 32'(pipeReq), 32'h0);
        checkOutput("init_words", 32'(wordsSent), 32'h1);
        countReq(5, seen);
        checkOutput("init_quiet", 32'(seen), 32'h0);

        // Link up with ack held: stable at edge 18, req at edge 19
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitReq(40, found, cycles);
        $display("[TB] link_up req after %0d cycles", cycles);
        checkOutput("link_found", 32'(found), 32'h1);
        checkOutput("link_latency_ok", 32'(cycles >= 18 && cycles <= 20), 32'h1);
        checkOutput("link_data", 32'(pipeData), 32'h11);
        @(negedge clk);
        checkOutput("link_req_drop", 32'(pipeReq), 32'h0);
        checkOutput("link_words", 32'(wordsSent), 32'h2);

        // 10-cycle glitch on reset_done must be rejected
        applyStimulus(1'b1, 1'b1, 1'b1);
        countReq(10, seen);
        checkOutput("glitch_req_during", 32'(seen), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        countReq(30, seen);
        checkOutput("glitch_req_after", 32'(seen), 32'h0);
        checkOutput("glitch_words", 32'(wordsSent), 32'h2);

        // Fresh start for the stalled back-to-back scenario
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitCycles(3);
        reset = 1'b0;
        waitCycles(4);
        checkOutput("rst2_words", 32'(wordsSent), 32'h1);
        checkOutput("rst2_req", 32'(pipeReq), 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        waitReq(40, found, cycles);
        checkOutput("stall_found", 32'(found), 32'h1);
        checkOutput("stall_data", 32'(pipeData), 32'h11);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(25);
        checkOutput("stall_hold_req", 32'(pipeReq), 32'h1);
        checkOutput("stall_hold_data", 32'(pipeData), 32'h11);
        checkOutput("stall_hold_words", 32'(wordsSent), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("b2b_req", 32'(pipeReq), 32'h1);
        checkOutput("b2b_data", 32'(pipeData), 32'h23);
        checkOutput("b2b_words", 32'(wordsSent), 32'h2);
        @(negedge clk);
        checkOutput("b2b_req_drop", 32'(pipeReq), 32'h0);
        checkOutput("b2b_words2", 32'(wordsSent), 32'h3);

        // Coalescing: link 1->0 pending, then 0->1->0 while stalled
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitReq(40, found, cycles);
        checkOutput("coal_found", 32'(found), 32'h1);
        checkOutput("coal_data", 32'(pipeData), 32'h32);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(25);
        checkOutput("coal_hold_data1", 32'(pipeData), 32'h32);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(25);
        checkOutput("coal_hold_data2", 32'(pipeData), 32'h32);
        checkOutput("coal_hold_req", 32'(pipeReq), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("coal_req_drop", 32'(pipeReq), 32'h0);
        checkOutput("coal_words", 32'(wordsSent), 32'h4);
        countReq(30, seen);
        checkOutput("coal_no_second", 32'(seen), 32'h0);
        checkOutput("coal_words_final", 32'(wordsSent), 32'h4);

        // Reset in the middle of a stalled send
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitReq(40, found, cycles);
        checkOutput("midrst_found", 32'(found), 32'h1);
        checkOutput("midrst_data", 32'(pipeData), 32'h43);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_req", 32'(pipeReq), 32'h0);
        checkOutput("midrst_words", 32'(wordsSent), 32'h0);
        @(negedge clk);
        checkOutput("reinit_req", 32'(pipeReq), 32'h1);
        checkOutput("reinit_data", 32'(pipeData), 32'h00);
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("reinit_words", 32'(wordsSent), 32'h1);
        waitReq(40, found, cycles);
        checkOutput("reacq_found", 32'(found), 32'h1);
        checkOutput("reacq_data", 32'(pipeData), 32'h13);
        @(negedge clk);
        checkOutput("reacq_words", 32'(wordsSent), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/nic_mac_status_pipe_tx.md
Name: nic_mac_status_pipe_tx

Overview:
- MAC-to-NIC return path. Reports MAC-side status (link up, reset done) to the NIC processor as words written into an AHIR-style output pipe.
- The pipe uses data/req/ack signalling; this block is the writer.
- Raw MAC status inputs are synchronised, then debounced.
- One word is sent after reset. After that, a word is sent on every debounced change. Changes that occur while a send is stalled are coalesced, so the latest value always wins.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its debounced value before the debounced value updates. Legal range 1..65535.
- DATA_WIDTH, 8: pipe word width. Fixed at 8; any other value is a synthesis-time error.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- MAC_LINK_UP  in  1  raw link status from the MAC, asynchronous to clk.
- MAC_RESET_DONE  in  1  raw MAC reset-complete flag, asynchronous to clk.
- MAC_STATUS_pipe_data  out  8  status word.
- MAC_STATUS_pipe_req  out  1  word valid; held high until accepted.
- MAC_STATUS_pipe_ack  in  1  reader ready. A transfer occurs in any cycle where req=1 and ack=1.
- words_sent  out  16  count of completed transfers; wraps at 0xFFFF.

Behaviour:
- Reset (reset=1 at posedge) clears:
  - synchroniser flops and debounce counters;
  - debounced values to 0;
  - last_sent to 0, seq to 0, words_sent to 0;
  - pipe_req to 0 and pipe_data to 0x00.
- FSM: the state goes to INIT on reset.
- Synchroniser: each raw input passes through a 2-flop synchroniser.
- Debounce (per bit):
  - If sync != stable, cnt increments. When cnt reaches DEBOUNCE_CYCLES-1 with the mismatch still present, stable takes the sync value and cnt clears.
  - If sync == stable, cnt clears.
  - Worst-case input-to-stable latency is 2 + DEBOUNCE_CYCLES cycles.
- Word format:
  - bit0 = link_up_stable
  - bit1 = reset_done_stable
  - bits3:2 = 2'b00
  - bits7:4 = seq, a 4-bit counter that increments after each transfer and wraps 15 to 0.
- FSM states: INIT, IDLE, SEND.
- INIT: lasts one cycle after reset deassertion. It loads pipe_data with the current status word, sets req=1 and moves to SEND. This makes the first word always carry seq=0.
- IDLE:
  - Stays while status == last_sent (status = the {reset_done,link_up} stable pair).
  - On mismatch, it registers the word, sets req=1 the next cycle and moves to SEND.
  - Latency from stable change to req=1 is 1 cycle.
- SEND:
  - pipe_data and req are held constant until ack=1.
  - On a transfer cycle, all of the following happen:
    - last_sent <= the status field of the word that was sent;
    - seq increments;
    - words_sent increments.
  - Next cycle after a transfer: if current status != last_sent, reload the word and keep req=1 (back-to-back send, no idle cycle). Otherwise clear req=0 and go to IDLE.
  - Status changes during a stalled SEND do not alter the held pipe_data. Intermediate values (e.g. 0→1→0 while stalled) are coalesced; only the status present after the transfer is compared.
- ack while req=0 is ignored.
- Reset mid-SEND: the pending word is dropped, req=0 at the next edge, and INIT re-sends status with seq=0.
- The block never asserts req without a registered word. Data is only allowed to change in the cycle after a transfer or when leaving IDLE.

Decomposition:
- Package nic_mac_status_pkg:
  - bit-position constants STAT_LINK_UP_BIT=0, STAT_RESET_DONE_BIT=1, STAT_SEQ_LSB=4;
  - FSM state encoding (INIT/IDLE/SEND).
- Sub-module nic_status_debounce (parameter DEBOUNCE_CYCLES): one instance per status bit. It contains the 2-flop synchroniser, the counter and the stable register; its output is the stable bit.

Test Plan:
- Reset release, ack=1, both inputs 0:
  - req rises 1 cycle after reset falls with data=0x00;
  - one transfer, then req=0;
  - words_sent=1.
- Hold ack=1, raise MAC_LINK_UP (DEBOUNCE_CYCLES=16):
  - req=1 with data=0x11 at cycle 2+16+1 (±1) after the edge;
  - words_sent=2.
- Glitch MAC_RESET_DONE high for 10 cycles with DEBOUNCE_CYCLES=16: no new req; words_sent unchanged.
- ack=0, set link=1, wait for req with data=0x11, then set reset_done=1 and wait for debounce:
  - data stays 0x11 until ack;
  - after ack, req stays high and data becomes 0x23 in the next cycle.
- Stalled send, link 0→1→0 fully debounced before ack: after the transfer, status equals last_sent, so req drops and no second word is sent.
- Assert reset for one cycle while req=1 and ack=0: req=0 next edge, then INIT re-sends the current status with seq=0 and words_sent=1.
